// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU: opcode map, fetch FSM encoding and
// the instruction-length helpers used by the fetch unit's decoder.
package cpu8_pkg;

    // Loads and stores, two bytes each (opcode + operand)
    localparam logic [7:0] LDA_IMM = 8'h10;
    localparam logic [7:0] LDA_ABS = 8'h11;
    localparam logic [7:0] STA_ABS = 8'h12;
    localparam logic [7:0] LDX_IMM = 8'h13;
    localparam logic [7:0] LDX_ABS = 8'h14;
    localparam logic [7:0] STX_ABS = 8'h15;

    // ALU operations, one byte each
    localparam logic [7:0] ADD     = 8'h20;
    localparam logic [7:0] SUB     = 8'h21;
    localparam logic [7:0] ANDA    = 8'h22;
    localparam logic [7:0] ORA     = 8'h23;
    localparam logic [7:0] EOR     = 8'h24;
    localparam logic [7:0] INCA    = 8'h25;
    localparam logic [7:0] DECA    = 8'h26;
    localparam logic [7:0] NOP     = 8'h27;

    // Branches, two bytes each (opcode + absolute target)
    localparam logic [7:0] JMP     = 8'h30;
    localparam logic [7:0] BEQ     = 8'h31;
    localparam logic [7:0] BNE     = 8'h32;
    localparam logic [7:0] BCS     = 8'h33;
    localparam logic [7:0] BCC     = 8'h34;
    localparam logic [7:0] BMI     = 8'h35;
    localparam logic [7:0] BPL     = 8'h36;
    localparam logic [7:0] CALL    = 8'h37;
    localparam logic [7:0] BCD     = 8'h38;

    // Fetch FSM: one ROM address cycle and one data cycle per byte, then issue
    typedef enum logic [2:0] {
        FETCH_OP  = 3'd0,
        WAIT_OP   = 3'd1,
        FETCH_ARG = 3'd2,
        WAIT_ARG  = 3'd3,
        ISSUE     = 3'd4
    } fetch_state_e;

    // True for opcodes that carry an operand byte
    function automatic logic is_two_byte(input logic [7:0] op);
        return ((op >= LDA_IMM) && (op <= STX_ABS)) ||
               ((op >= JMP) && (op <= BCD));
    endfunction

    // True for single-byte ALU opcodes
    function automatic logic is_alu(input logic [7:0] op);
        return (op >= ADD) && (op <= NOP);
    endfunction

    // True for any opcode in the instruction set
    function automatic logic is_legal(input logic [7:0] op);
        return is_two_byte(op) || is_alu(op);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus between the fetch unit, the program ROM and the execute stage.
// master = fetch unit side, slave = ROM plus execute/control side.
interface instr_fetch_unit_if;

    logic [7:0] rom_addr;
    logic       rom_en;
    logic [7:0] rom_data;

    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       has_operand;
    logic       illegal_op;

    logic       branch_taken;
    logic [7:0] branch_target;

    modport master (
        output rom_addr, rom_en,
        input  rom_data,
        output instr_valid, opcode, operand, has_operand, illegal_op,
        input  instr_ready, branch_taken, branch_target
    );

    modport slave (
        input  rom_addr, rom_en,
        output rom_data,
        input  instr_valid, opcode, operand, has_operand, illegal_op,
        output instr_ready, branch_taken, branch_target
    );

endinterface

// File: rtl/instr_length_decoder.sv
// Purely combinational opcode classifier: instruction length and legality.
// Unknown opcodes are reported illegal and treated as single-byte.
module instr_length_decoder
    import cpu8_pkg::*;
(
    input  logic [7:0] op,
    output logic       has_operand,
    output logic       illegal_op
);

    // Classify the opcode byte currently on the ROM data bus
    always_comb begin
        has_operand = is_two_byte(op);
        illegal_op  = !is_legal(op);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Front end of the 8-bit CPU. Owns the program counter, walks the synchronous
// program ROM one byte at a time and hands complete instructions to the
// execute stage over a valid/ready handshake. No prefetch: the next fetch
// starts the cycle after an instruction is accepted, so a branch redirect
// never has to squash anything.
module instr_fetch_unit
    import cpu8_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter int         ROM_DEPTH = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    instr_fetch_unit_if.master        bus,
    output logic [7:0]                pc
);

    fetch_state_e state_q, state_d;
    logic [7:0]   pc_q, pc_d;
    logic [7:0]   opcode_q, opcode_d;
    logic [7:0]   operand_q, operand_d;
    logic         has_operand_q, has_operand_d;
    logic         illegal_op_q, illegal_op_d;

    logic         dec_has_operand;
    logic         dec_illegal_op;

    // The decoder looks at the raw ROM byte; its result only matters in WAIT_OP
    instr_length_decoder u_length_decoder (
        .op          (bus.rom_data),
        .has_operand (dec_has_operand),
        .illegal_op  (dec_illegal_op)
    );

    // Next-state logic: sequence the byte fetches, latch the instruction, redirect on accept
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        opcode_d      = opcode_q;
        operand_d     = operand_q;
        has_operand_d = has_operand_q;
        illegal_op_d  = illegal_op_q;

        case (state_q)
            FETCH_OP: begin
                state_d = WAIT_OP;
            end

            WAIT_OP: begin
                opcode_d      = bus.rom_data;
                pc_d          = pc_q + 8'd1;
                has_operand_d = dec_has_operand;
                illegal_op_d  = dec_illegal_op;
                if (dec_has_operand) begin
                    state_d = FETCH_ARG;
                end else begin
                    operand_d = 8'h00;
                    state_d   = ISSUE;
                end
            end

            FETCH_ARG: begin
                state_d = WAIT_ARG;
            end

            WAIT_ARG: begin
                operand_d = bus.rom_data;
                pc_d      = pc_q + 8'd1;
                state_d   = ISSUE;
            end

            ISSUE: begin
                if (bus.instr_ready) begin
                    pc_d    = bus.branch_taken ? bus.branch_target : pc_q;
                    state_d = FETCH_OP;
                end
            end

            default: begin
                state_d = FETCH_OP;
            end
        endcase
    end

    // State register; reset discards any partial or pending instruction
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH_OP;
            pc_q          <= RESET_PC;
            opcode_q      <= 8'h00;
            operand_q     <= 8'h00;
            has_operand_q <= 1'b0;
            illegal_op_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            opcode_q      <= opcode_d;
            operand_q     <= operand_d;
            has_operand_q <= has_operand_d;
            illegal_op_q  <= illegal_op_d;
        end
    end

    // The ROM address is always the PC; locations past the implemented depth are not enabled
    assign bus.rom_addr    = pc_q;
    assign bus.rom_en      = (int'(pc_q) < ROM_DEPTH);

    assign bus.instr_valid = (state_q == ISSUE);
    assign bus.opcode      = opcode_q;
    assign bus.operand     = operand_q;
    assign bus.has_operand = has_operand_q;
    assign bus.illegal_op  = illegal_op_q;

    assign pc              = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Two instances: one at RESET_PC=00
// for the main scenarios and one at RESET_PC=FE for the address wrap.
// Expected instructions are queued by the stimulus thread and compared by
// per-instance monitors whenever instr_valid is high.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] operand;
        logic       has_operand;
        logic       illegal_op;
        logic [7:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_a;
    logic       reset_b;
    logic [7:0] pc_a;
    logic [7:0] pc_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    exp_t exp_a[$];
    exp_t exp_b[$];

    int checks   = 0;
    int failures = 0;

    instr_fetch_unit_if if_a ();
    instr_fetch_unit_if if_b ();

    instr_fetch_unit #(.RESET_PC(8'h00), .ROM_DEPTH(128)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (if_a),
        .pc    (pc_a)
    );

    instr_fetch_unit #(.RESET_PC(8'hFE), .ROM_DEPTH(128)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (if_b),
        .pc    (pc_b)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models, one-cycle read latency
    always @(posedge clk) if_a.rom_data <= mem_a[if_a.rom_addr];
    always @(posedge clk) if_b.rom_data <= mem_b[if_b.rom_addr];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic compareItem(input string tag, input logic [7:0] op, input logic [7:0] arg,
                               input logic has, input logic ill, input logic [7:0] pcv, input exp_t e);
        checkOutput({tag, "_opcode"}, op, e.opcode);
        checkOutput({tag, "_operand"}, arg, e.operand);
        checkOutput({tag, "_has_operand"}, has, e.has_operand);
        checkOutput({tag, "_illegal_op"}, ill, e.illegal_op);
        checkOutput({tag, "_pc"}, pcv, e.pc);
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [7:0] arg,
                                input logic has, input logic ill, input logic [7:0] pcv);
        exp_t e;
        e.opcode      = op;
        e.operand     = arg;
        e.has_operand = has;
        e.illegal_op  = ill;
        e.pc          = pcv;
        return e;
    endfunction

    // Monitor for instance A: every valid cycle must match the queue head; pop on accept
    always @(negedge clk) begin
        if (reset_a === 1'b1 && if_a.instr_valid === 1'b1) begin
            if (exp_a.size() > 0) begin
                compareItem("a_issue", if_a.opcode, if_a.operand, if_a.has_operand,
                            if_a.illegal_op, pc_a, exp_a[0]);
                if (if_a.instr_ready) void'(exp_a.pop_front());
            end else if (if_a.instr_ready) begin
                checks++;
                failures++;
                $display("[TB] FAIL a_unexpected_accept: actual opcode=%0h required no instruction", if_a.opcode);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (reset_b === 1'b1 && if_b.instr_valid === 1'b1) begin
            if (exp_b.size() > 0) begin
                compareItem("b_issue", if_b.opcode, if_b.operand, if_b.has_operand,
                            if_b.illegal_op, pc_b, exp_b[0]);
                if (if_b.instr_ready) void'(exp_b.pop_front());
            end else if (if_b.instr_ready) begin
                checks++;
                failures++;
                $display("[TB] FAIL b_unexpected_accept: actual opcode=%0h required no instruction", if_b.opcode);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ready, input logic taken, input logic [7:0] target);
        if_a.instr_ready   = ready;
        if_a.branch_taken  = taken;
        if_a.branch_target = target;
    endtask

    task automatic pushA(input logic [7:0] op, input logic [7:0] arg, input logic has,
                         input logic ill, input logic [7:0] pcv);
        exp_a.push_back(mk(op, arg, has, ill, pcv));
    endtask

    task automatic clearRomA();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;
    endtask

    // Two reset edges, checking the reset state after the first; returns in cycle 1 (FETCH_OP)
    task automatic resetA();
        reset_a = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick();
        checkOutput("rst_pc", pc_a, 8'h00);
        checkOutput("rst_valid", if_a.instr_valid, 1'b0);
        checkOutput("rst_opcode", if_a.opcode, 8'h00);
        checkOutput("rst_operand", if_a.operand, 8'h00);
        checkOutput("rst_has_operand", if_a.has_operand, 1'b0);
        checkOutput("rst_illegal_op", if_a.illegal_op, 1'b0);
        tick();
        reset_a = 1'b1;
    endtask

    task automatic waitDrainA(input int budget, input string name);
        int n = 0;
        while (exp_a.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, exp_a.size(), 0);
    endtask

    // Watchdog so the run always reaches a summary line
    initial begin
        #100000;
        failures++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        if_b.instr_ready   = 1'b0;
        if_b.branch_taken  = 1'b0;
        if_b.branch_target = 8'h00;
        clearRomA();
        for (int i = 0; i < 256; i++) mem_b[i] = 8'h00;

        // Program 10 AA 14 E0 30 00, branch at 04 back to 00; 2-byte period is 5 cycles
        $display("[TB] scenario: two-byte program with branch back to 00");
        mem_a[0] = 8'h10; mem_a[1] = 8'hAA; mem_a[2] = 8'h14;
        mem_a[3] = 8'hE0; mem_a[4] = 8'h30; mem_a[5] = 8'h00;
        pushA(8'h10, 8'hAA, 1'b1, 1'b0, 8'h02);
        pushA(8'h14, 8'hE0, 1'b1, 1'b0, 8'h04);
        pushA(8'h30, 8'h00, 1'b1, 1'b0, 8'h06);
        pushA(8'h10, 8'hAA, 1'b1, 1'b0, 8'h02);
        resetA();
        for (int c = 1; c <= 20; c++) begin
            checkOutput($sformatf("t1_valid_c%0d", c), if_a.instr_valid, (c % 5 == 0));
            checkOutput($sformatf("t1_rom_en_c%0d", c), if_a.rom_en, 1'b1);
            if (c == 16) checkOutput("t1_pc_after_branch", pc_a, 8'h00);
            if (c >= 11 && c <= 14)  applyStimulus(1'b1, 1'b1, 8'h44);
            else if (c == 15)        applyStimulus(1'b1, 1'b1, 8'h00);
            else                     applyStimulus(1'b1, 1'b0, 8'h00);
            tick();
        end
        checkOutput("t1_drained", exp_a.size(), 0);

        // One-byte op with 4 cycles of back-pressure, then a second one-byte op
        $display("[TB] scenario: one-byte latency and back-pressure");
        clearRomA();
        mem_a[0] = 8'h24; mem_a[1] = 8'h25;
        pushA(8'h24, 8'h00, 1'b0, 1'b0, 8'h01);
        pushA(8'h25, 8'h00, 1'b0, 1'b0, 8'h02);
        resetA();
        for (int c = 1; c <= 10; c++) begin
            checkOutput($sformatf("t2_valid_c%0d", c), if_a.instr_valid,
                        ((c >= 3 && c <= 7) || c == 10));
            if (c >= 3 && c <= 7) begin
                checkOutput($sformatf("t2_hold_opcode_c%0d", c), if_a.opcode, 8'h24);
                checkOutput($sformatf("t2_hold_operand_c%0d", c), if_a.operand, 8'h00);
                checkOutput($sformatf("t2_hold_pc_c%0d", c), pc_a, 8'h01);
            end
            if (c == 8) checkOutput("t2_next_fetch_addr", if_a.rom_addr, 8'h01);
            applyStimulus((c >= 7), 1'b0, 8'h00);
            tick();
        end
        checkOutput("t2_drained", exp_a.size(), 0);

        // Decode sweep including range edges and illegal opcodes
        $display("[TB] scenario: length decode sweep");
        clearRomA();
        mem_a[8'h00] = 8'h11; mem_a[8'h01] = 8'h5C;
        mem_a[8'h02] = 8'h26; mem_a[8'h03] = 8'h27; mem_a[8'h04] = 8'h20;
        mem_a[8'h05] = 8'hFF;
        mem_a[8'h06] = 8'h12; mem_a[8'h07] = 8'h9B;
        mem_a[8'h08] = 8'h15; mem_a[8'h09] = 8'h01;
        mem_a[8'h0A] = 8'h16;
        mem_a[8'h0B] = 8'h38; mem_a[8'h0C] = 8'h02;
        mem_a[8'h0D] = 8'h0F; mem_a[8'h0E] = 8'h28; mem_a[8'h0F] = 8'h39;
        pushA(8'h11, 8'h5C, 1'b1, 1'b0, 8'h02);
        pushA(8'h26, 8'h00, 1'b0, 1'b0, 8'h03);
        pushA(8'h27, 8'h00, 1'b0, 1'b0, 8'h04);
        pushA(8'h20, 8'h00, 1'b0, 1'b0, 8'h05);
        pushA(8'hFF, 8'h00, 1'b0, 1'b1, 8'h06);
        pushA(8'h12, 8'h9B, 1'b1, 1'b0, 8'h08);
        pushA(8'h15, 8'h01, 1'b1, 1'b0, 8'h0A);
        pushA(8'h16, 8'h00, 1'b0, 1'b1, 8'h0B);
        pushA(8'h38, 8'h02, 1'b1, 1'b0, 8'h0D);
        pushA(8'h0F, 8'h00, 1'b0, 1'b1, 8'h0E);
        pushA(8'h28, 8'h00, 1'b0, 1'b1, 8'h0F);
        pushA(8'h39, 8'h00, 1'b0, 1'b1, 8'h10);
        resetA();
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitDrainA(120, "t3_drained");
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Tight loop: branch at 00 targeting its own address
        $display("[TB] scenario: branch to own address");
        clearRomA();
        mem_a[0] = 8'h30; mem_a[1] = 8'h00;
        for (int i = 0; i < 3; i++) pushA(8'h30, 8'h00, 1'b1, 1'b0, 8'h02);
        resetA();
        applyStimulus(1'b1, 1'b1, 8'h00);
        waitDrainA(60, "t4_drained");
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset during WAIT_ARG discards the instruction; fetch restarts right after release
        $display("[TB] scenario: reset during operand fetch");
        clearRomA();
        mem_a[0] = 8'h14; mem_a[1] = 8'hE0;
        pushA(8'h14, 8'hE0, 1'b1, 1'b0, 8'h02);
        resetA();
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            checkOutput($sformatf("t5_valid_c%0d", c), if_a.instr_valid, 1'b0);
            tick();
        end
        checkOutput("t5_pc_wait_arg", pc_a, 8'h01);
        checkOutput("t5_valid_c4", if_a.instr_valid, 1'b0);
        reset_a = 1'b0;
        tick();
        reset_a = 1'b1;
        checkOutput("t5_pc_after_reset", pc_a, 8'h00);
        checkOutput("t5_opcode_after_reset", if_a.opcode, 8'h00);
        checkOutput("t5_rom_addr_restart", if_a.rom_addr, 8'h00);
        for (int c = 5; c <= 9; c++) begin
            checkOutput($sformatf("t5_valid_c%0d", c), if_a.instr_valid, (c == 9));
            tick();
        end
        checkOutput("t5_drained", exp_a.size(), 0);
        applyStimulus(1'b0, 1'b0, 8'h00);

        // PC wrap on the second instance: operand at FF, pc reaches 00 after WAIT_ARG
        $display("[TB] scenario: pc wrap with operand at FF");
        begin
            logic [7:0] pcs [5];
            int n;
            pcs[0] = 8'hFE; pcs[1] = 8'hFE; pcs[2] = 8'hFF; pcs[3] = 8'hFF; pcs[4] = 8'h00;
            mem_b[8'hFE] = 8'h13; mem_b[8'hFF] = 8'hC3; mem_b[8'h00] = 8'h25;
            exp_b.push_back(mk(8'h13, 8'hC3, 1'b1, 1'b0, 8'h00));
            exp_b.push_back(mk(8'h25, 8'h00, 1'b0, 1'b0, 8'h01));
            reset_b = 1'b0;
            tick();
            checkOutput("t6_rst_pc", pc_b, 8'hFE);
            tick();
            reset_b = 1'b1;
            if_b.instr_ready = 1'b1;
            for (int c = 1; c <= 5; c++) begin
                checkOutput($sformatf("t6_pc_c%0d", c), pc_b, pcs[c-1]);
                checkOutput($sformatf("t6_rom_addr_c%0d", c), if_b.rom_addr, pcs[c-1]);
                checkOutput($sformatf("t6_rom_en_c%0d", c), if_b.rom_en, (c == 5));
                checkOutput($sformatf("t6_valid_c%0d", c), if_b.instr_valid, (c == 5));
                tick();
            end
            n = 0;
            while (exp_b.size() != 0 && n < 20) begin
                tick();
                n++;
            end
            checkOutput("t6_drained", exp_b.size(), 0);
            if_b.instr_ready = 1'b0;
        end

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
